// File: rtl/snn_noc_pkg.sv
// ---------------------------------------------------------------------------
// snn_noc_pkg
//   Shared NoC packet definitions for the SNN accelerator memory controller.
//   64-bit packet layout:
//     [63:60] source address
//     [59:56] destination address
//     [55:54] packet type (00 input, 01 kernel, 11 output)
//     [53:0]  payload, zero-extended
//   An output-type packet whose payload[9:0] equals DONE_CODE is a DONE marker
//   rather than a spike coordinate.
// ---------------------------------------------------------------------------
package snn_noc_pkg;

  localparam int PKT_W       = 64;
  localparam int SRC_MSB     = 63;
  localparam int SRC_LSB     = 60;
  localparam int DST_MSB     = 59;
  localparam int DST_LSB     = 56;
  localparam int TYPE_MSB    = 55;
  localparam int TYPE_LSB    = 54;
  localparam int PAYLOAD_MSB = 53;
  localparam int PAYLOAD_W   = 54;

  localparam logic [9:0] DONE_CODE = 10'h3FF;

  typedef enum logic [1:0] {
    PKT_INPUT  = 2'b00,
    PKT_KERNEL = 2'b01,
    PKT_OUTPUT = 2'b11
  } pkt_type_e;

  typedef enum logic [1:0] {
    IDLE,
    FILT,
    IFM,
    WAIT_OUT
  } ctrl_state_e;

  function automatic logic [PKT_W-1:0] pkt_build(
    input logic [3:0]           src,
    input logic [3:0]           dst,
    input pkt_type_e            ptype,
    input logic [PAYLOAD_W-1:0] payload
  );
    return {src, dst, ptype, payload};
  endfunction

endpackage

// File: rtl/spike_pkt_tx.sv
// ---------------------------------------------------------------------------
// spike_pkt_tx
//   Outbound packet holding register with valid/ready handshake.
//   The owner pulses load only when the register is free (empty, or its
//   packet is being accepted this cycle), so the held packet never changes
//   while valid && !ready.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture load_data and raise valid next cycle
//   load_data   packet to present
//   ready       downstream accepts the presented packet
//   valid       packet valid
//   data        presented packet
// ---------------------------------------------------------------------------
module spike_pkt_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic        ready,
  output logic        valid,
  output logic [63:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      // A load in the same cycle as a handshake replaces the accepted packet,
      // giving back-to-back throughput.
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/spike_mem_ctrl.sv
// ---------------------------------------------------------------------------
// spike_mem_ctrl
//   On-chip filter / ifmap / ofmap storage for the SNN accelerator. Streams
//   filter rows, then per-timestep ifmap rows, to the PEs as NoC packets, and
//   collects output spikes plus DONE markers that close each timestep.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, accepted only when idle
//   busy, run_done      run in progress / pulse when last timestep closes
//   cur_t               current timestep
//   ld_en/sel/addr/data preload port (ignored while busy)
//   pkt_out_*           outbound packet stream (valid/ready)
//   pkt_in_*            inbound packet stream (valid/ready)
//   ofm_rd_*            ofmap readback, one-cycle latency
//   err                 sticky: a malformed inbound packet was dropped
// ---------------------------------------------------------------------------
module spike_mem_ctrl
  import snn_noc_pkg::*;
#(
  parameter int                    TIMESTEPS = 10,
  parameter int                    FR        = 5,
  parameter int                    FC        = 5,
  parameter int                    FW        = 8,
  parameter int                    IR        = 25,
  parameter int                    IC        = 25,
  parameter int                    OR        = 21,
  parameter int                    OC        = 21,
  parameter int                    NUM_PE    = 5,
  parameter logic [NUM_PE*4-1:0]   PE_ADDR   = {4'h9, 4'h3, 4'h2, 4'h1, 4'h0},
  parameter logic [3:0]            SRC_ADDR  = 4'h0,
  parameter int                    NUM_DONE  = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          run_done,
  output logic [$clog2(TIMESTEPS+1)-1:0] cur_t,
  input  logic                          ld_en,
  input  logic                          ld_sel,
  input  logic [31:0]                   ld_addr,
  input  logic [FW-1:0]                 ld_data,
  output logic                          pkt_out_valid,
  input  logic                          pkt_out_ready,
  output logic [63:0]                   pkt_out_data,
  input  logic                          pkt_in_valid,
  output logic                          pkt_in_ready,
  input  logic [63:0]                   pkt_in_data,
  input  logic                          ofm_rd_en,
  input  logic [$clog2(TIMESTEPS)-1:0]  ofm_rd_t,
  input  logic [4:0]                    ofm_rd_row,
  input  logic [4:0]                    ofm_rd_col,
  output logic                          ofm_rd_data,
  output logic                          ofm_rd_valid,
  output logic                          err
);

  localparam int TW      = $clog2(TIMESTEPS + 1);
  localparam int MAXROWS = (FR > IR) ? FR : IR;
  localparam int RW      = $clog2(MAXROWS + 1);
  localparam int PW      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int DW      = $clog2(NUM_DONE + 1);
  localparam int FILT_N  = FR * FC;
  localparam int IFM_N   = TIMESTEPS * IR * IC;
  localparam int OFM_N   = TIMESTEPS * OR;
  localparam int FILT_AW = $clog2(FILT_N);
  localparam int IFM_AW  = $clog2(IFM_N);
  localparam int OFM_AW  = $clog2(OFM_N);

  // ---------------------------------------------------------------------------
  // Storage. Filter and ifmap are preloaded and never reset. The ofmap is one
  // OC-wide word per (timestep, row) so it can be bulk-cleared on start.
  // ---------------------------------------------------------------------------
  logic [FW-1:0] filt_mem [FILT_N];
  logic          ifm_mem  [IFM_N];
  logic [OC-1:0] ofm_mem  [OFM_N];

  ctrl_state_e   state_reg, state_next;
  logic [RW-1:0] row_reg, row_next;
  logic [PW-1:0] pe_reg, pe_next, pe_inc;
  logic [TW-1:0] cur_t_reg, cur_t_next;
  logic [DW-1:0] done_cnt_reg, done_cnt_next;
  logic          err_reg, err_next;
  logic          run_done_reg, run_done_next;

  // Packet to load into the outbound holding register this cycle.
  logic          tx_load;
  logic          tx_kernel;
  logic [RW-1:0] tx_row;
  logic [PW-1:0] tx_pe;
  logic [TW-1:0] tx_t;
  logic [63:0]   tx_data;

  logic out_hs;
  logic ofm_clear;
  logic ofm_set;

  // Inbound packet fields.
  logic [1:0] in_type;
  logic [9:0] in_code;
  logic [4:0] in_row;
  logic [4:0] in_col;
  logic       unused_in_bits;

  assign in_type        = pkt_in_data[TYPE_MSB:TYPE_LSB];
  assign in_code        = pkt_in_data[9:0];
  assign in_row         = pkt_in_data[9:5];
  assign in_col         = pkt_in_data[4:0];
  assign unused_in_bits = ^{pkt_in_data[SRC_MSB:DST_LSB], pkt_in_data[PAYLOAD_MSB:10]};

  assign busy         = (state_reg != IDLE);
  assign run_done     = run_done_reg;
  assign cur_t        = cur_t_reg;
  assign err          = err_reg;
  assign pkt_in_ready = (state_reg == WAIT_OUT);
  assign out_hs       = pkt_out_valid && pkt_out_ready;
  assign pe_inc       = (pe_reg == PW'(NUM_PE - 1)) ? '0 : pe_reg + PW'(1);

  // ---------------------------------------------------------------------------
  // Preload writes. Range checks come before the address is truncated so an
  // oversize address can never alias onto a valid location.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ld_en && !busy) begin
      if (!ld_sel && (ld_addr < 32'(FILT_N))) begin
        filt_mem[ld_addr[FILT_AW-1:0]] <= ld_data;
      end
      if (ld_sel && (ld_addr < 32'(IFM_N))) begin
        ifm_mem[ld_addr[IFM_AW-1:0]] <= ld_data[0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Row gather for the packet being loaded.
  // ---------------------------------------------------------------------------
  logic [31:0]          filt_base;
  logic [31:0]          ifm_base;
  logic [FC*FW-1:0]     filt_row;
  logic [IC-1:0]        ifm_row;
  logic [PAYLOAD_W-1:0] tx_payload;
  logic [3:0]           tx_dst;

  assign filt_base = 32'(tx_row) * FC;
  assign ifm_base  = (32'(tx_t) * IR + 32'(tx_row)) * IC;

  genvar gi;
  generate
    for (gi = 0; gi < FC; gi++) begin : g_filt_gather
      assign filt_row[gi*FW +: FW] = filt_mem[FILT_AW'(filt_base + 32'(gi))];
    end
    for (gi = 0; gi < IC; gi++) begin : g_ifm_gather
      assign ifm_row[gi] = ifm_mem[IFM_AW'(ifm_base + 32'(gi))];
    end
  endgenerate

  always_comb begin
    tx_payload = '0;
    if (tx_kernel) begin
      tx_payload[FC*FW-1:0] = filt_row;
    end else begin
      tx_payload[IC-1:0] = ifm_row;
    end
  end

  assign tx_dst  = PE_ADDR[32'(tx_pe)*4 +: 4];
  assign tx_data = pkt_build(SRC_ADDR, tx_dst, tx_kernel ? PKT_KERNEL : PKT_INPUT, tx_payload);

  spike_pkt_tx u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_load),
    .load_data (tx_data),
    .ready     (pkt_out_ready),
    .valid     (pkt_out_valid),
    .data      (pkt_out_data)
  );

  // ---------------------------------------------------------------------------
  // Control FSM: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      row_reg      <= '0;
      pe_reg       <= '0;
      cur_t_reg    <= '0;
      done_cnt_reg <= '0;
      err_reg      <= 1'b0;
      run_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      row_reg      <= row_next;
      pe_reg       <= pe_next;
      cur_t_reg    <= cur_t_next;
      done_cnt_reg <= done_cnt_next;
      err_reg      <= err_next;
      run_done_reg <= run_done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and outputs. row_reg/pe_reg always describe the
  // packet currently held in the outbound register; a handshake loads the
  // following row in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    row_next      = row_reg;
    pe_next       = pe_reg;
    cur_t_next    = cur_t_reg;
    done_cnt_next = done_cnt_reg;
    err_next      = err_reg;
    run_done_next = 1'b0;
    tx_load       = 1'b0;
    tx_kernel     = 1'b0;
    tx_row        = row_reg;
    tx_pe         = pe_reg;
    tx_t          = cur_t_reg;
    ofm_clear     = 1'b0;
    ofm_set       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = FILT;
          row_next      = '0;
          pe_next       = '0;
          cur_t_next    = '0;
          done_cnt_next = '0;
          err_next      = 1'b0;
          ofm_clear     = 1'b1;
          tx_load       = 1'b1;
          tx_kernel     = 1'b1;
          tx_row        = '0;
          tx_pe         = '0;
        end
      end

      FILT: begin
        if (out_hs) begin
          tx_load = 1'b1;
          if (row_reg == RW'(FR - 1)) begin
            // Filter done: first ifmap row of the current timestep follows.
            state_next = IFM;
            row_next   = '0;
            pe_next    = '0;
            tx_kernel  = 1'b0;
          end else begin
            row_next   = row_reg + RW'(1);
            pe_next    = pe_inc;
            tx_kernel  = 1'b1;
          end
          tx_row = row_next;
          tx_pe  = pe_next;
        end
      end

      IFM: begin
        if (out_hs) begin
          if (row_reg == RW'(IR - 1)) begin
            state_next = WAIT_OUT;
            row_next   = '0;
            pe_next    = '0;
          end else begin
            row_next = row_reg + RW'(1);
            pe_next  = pe_inc;
            tx_load  = 1'b1;
            tx_row   = row_next;
            tx_pe    = pe_next;
          end
        end
      end

      WAIT_OUT: begin
        if (pkt_in_valid) begin
          if (pkt_type_e'(in_type) != PKT_OUTPUT) begin
            err_next = 1'b1;
          end else if (in_code == DONE_CODE) begin
            if (done_cnt_reg == DW'(NUM_DONE - 1)) begin
              done_cnt_next = '0;
              cur_t_next    = cur_t_reg + TW'(1);
              if (cur_t_next == TW'(TIMESTEPS)) begin
                state_next    = IDLE;
                run_done_next = 1'b1;
              end else begin
                state_next = IFM;
                row_next   = '0;
                pe_next    = '0;
                tx_load    = 1'b1;
                tx_row     = '0;
                tx_pe      = '0;
                tx_t       = cur_t_next;
              end
            end else begin
              done_cnt_next = done_cnt_reg + DW'(1);
            end
          end else if ((in_row < 5'(OR)) && (in_col < 5'(OC))) begin
            ofm_set = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Ofmap: cleared on reset and on start acceptance, set by spike packets.
  // ---------------------------------------------------------------------------
  logic [OFM_AW-1:0] ofm_wr_idx;
  assign ofm_wr_idx = OFM_AW'(32'(cur_t_reg) * OR + 32'(in_row));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OFM_N; i++) ofm_mem[i] <= '0;
    end else if (ofm_clear) begin
      for (int i = 0; i < OFM_N; i++) ofm_mem[i] <= '0;
    end else if (ofm_set) begin
      ofm_mem[ofm_wr_idx][in_col] <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Readback, one-cycle latency; out-of-range coordinates read as 0.
  // ---------------------------------------------------------------------------
  logic              rd_in_range;
  logic [OFM_AW-1:0] rd_idx;

  assign rd_in_range = (32'(ofm_rd_t) < 32'(TIMESTEPS)) &&
                       (ofm_rd_row < 5'(OR)) && (ofm_rd_col < 5'(OC));
  assign rd_idx      = OFM_AW'(32'(ofm_rd_t) * OR + 32'(ofm_rd_row));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofm_rd_valid <= 1'b0;
      ofm_rd_data  <= 1'b0;
    end else begin
      ofm_rd_valid <= ofm_rd_en;
      if (ofm_rd_en) begin
        ofm_rd_data <= rd_in_range ? ofm_mem[rd_idx][ofm_rd_col] : 1'b0;
      end
    end
  end

endmodule
